fp16_out_skid_pipe: RTL and testbench
=====================================

Name: fp16_out_skid_pipe

Overview:
- Registered output stage directly downstream of the fp17-to-fp16 core output channel interface.
- Consumes the core's 16-bit valid/ready result stream: chn_o_rsc_lz drives in_pvld, chn_o_rsc_z drives in_pd, and in_prdy drives chn_o_rsc_vz.
- Re-times the stream toward the consuming pipeline with a 2-entry skid buffer: all outputs registered, full throughput.
- Also provides an occupancy indication and a wrapping output-transfer counter for debug.

Parameters:
- WIDTH, 16, payload width in bits (fp16 result).
- CNT_W, 16, width of the output transfer counter.

Ports:
- nvdla_core_clk  input  1  core clock; all state updates on the rising edge.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- in_pvld  input  1  upstream data valid (from chn_o_rsc_lz).
- in_prdy  output  1  upstream ready (to chn_o_rsc_vz); registered.
- in_pd  input  WIDTH  upstream payload (from chn_o_rsc_z).
- out_pvld  output  1  downstream valid; registered.
- out_prdy  input  1  downstream ready.
- out_pd  output  WIDTH  downstream payload; registered.
- occ  output  2  entries held: 0, 1 or 2.
- cnt_clr  input  1  synchronous clear of xfer_cnt.
- xfer_cnt  output  CNT_W  number of completed output transfers, wrapping.

Behaviour:
- Definitions:
  - acc = in_pvld & in_prdy
  - fire = out_pvld & out_prdy
  - Storage: main register (pipe_vld, pipe_pd) and skid register (skid_vld, skid_pd).
  - out_pvld = pipe_vld, out_pd = pipe_pd, in_prdy = ~skid_vld. All are flop outputs; no combinational path from out_prdy to in_prdy.
- Reset (asynchronous, while nvdla_core_rstn = 0):
  - pipe_vld = 0, skid_vld = 0, pipe_pd = 0, skid_pd = 0, xfer_cnt = 0.
  - Resulting outputs: out_pvld = 0, in_prdy = 1, occ = 0, out_pd = 0.
  - Reset mid-operation discards held data immediately; no transfer is counted.
- State encoding {pipe_vld, skid_vld}: EMPTY = 00, HALF = 10, FULL = 11. State 01 is illegal and unreachable.
- EMPTY:
  - acc -> HALF, pipe_pd <= in_pd.
  - otherwise stay.
  - fire is impossible in EMPTY.
- HALF:
  - acc & fire -> HALF, pipe_pd <= in_pd.
  - acc & ~fire -> FULL, skid_pd <= in_pd; pipe_pd held.
  - ~acc & fire -> EMPTY.
  - neither -> hold.
- FULL:
  - in_prdy = 0, so acc is impossible.
  - fire -> HALF, pipe_pd <= skid_pd.
  - otherwise hold.
- Latency and throughput:
  - Data accepted in cycle N is visible on out_pd in cycle N+1 when the stage was EMPTY, or when it was HALF and fired.
  - Sustained throughput is 1 transfer per cycle with out_prdy held high.
- Ordering: strict FIFO; no drop, no duplication.
- Stability: while out_pvld = 1 and out_prdy = 0, out_pd and out_pvld must not change.
- Don't-care inputs: in_pd is ignored when in_pvld = 0. out_prdy is ignored when out_pvld = 0; it causes no count and no state change.
- occ = pipe_vld + skid_vld.
- xfer_cnt:
  - Increments by 1 on each fire; wraps from 2^CNT_W-1 to 0.
  - cnt_clr has priority: cnt_clr & fire -> xfer_cnt <= 0 in that cycle, and that transfer is not counted.
- Simultaneous events:
  - HALF with acc & fire replaces the main entry with no bubble.
  - FULL with fire frees the skid entry; in_prdy rises in the next cycle.
- Payload is passed bit-exact; no arithmetic is performed on the data.

Test Plan:
- Reset then idle: rstn low 3 cycles, in_pvld = 0 -> out_pvld = 0, in_prdy = 1, occ = 0, xfer_cnt = 0.
- Streaming: out_prdy = 1, push 0x3C00, 0x4000, 0x4200 on consecutive cycles -> same values on out_pd one cycle later, back-to-back, xfer_cnt = 3, occ stays <= 1.
- Backpressure: out_prdy = 0, push 0x1111, 0x2222 -> occ = 2 and in_prdy = 0 the cycle after the second accept. A third word 0x3333 held on in_pvld is not accepted. out_pd holds 0x1111 stable.
- Release after backpressure: raise out_prdy -> out_pd sequence 0x1111, 0x2222, 0x3333 with no loss or duplication; in_prdy returns to 1 one cycle after the first fire.
- Counter wrap and clear: CNT_W = 4, 17 fires -> xfer_cnt = 1. Assert cnt_clr in the same cycle as a fire -> xfer_cnt = 0.
- Async reset mid-operation: in FULL holding 0xAAAA/0xBBBB, drop rstn between clock edges -> out_pvld = 0, occ = 0, in_prdy = 1 immediately, before the next edge. After release, the next push 0xCCCC is the first word output.

Source files
------------

// File: rtl/fp16_out_skid_pipe.sv
// Registered 2-entry skid output stage for the fp17-to-fp16 result stream.
// Full throughput with flop-only outputs, plus an occupancy and transfer-count debug view.
module fp16_out_skid_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             in_pvld,
   output logic             in_prdy,
   input  logic [WIDTH-1:0] in_pd,
   output logic             out_pvld,
   input  logic             out_prdy,
   output logic [WIDTH-1:0] out_pd,
   output logic [1:0]       occ,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] xfer_cnt
);

   // Encoding is {pipe_vld, skid_vld}; 01 is never entered.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      HALF  = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] pipe_pd;
   logic [WIDTH-1:0] pipe_pd_nxt;
   logic [WIDTH-1:0] skid_pd;
   logic [WIDTH-1:0] skid_pd_nxt;
   logic             pipe_vld;
   logic             skid_vld;
   logic             acc_c;
   logic             fire_c;

   assign pipe_vld = state[1];
   assign skid_vld = state[0];
   assign acc_c    = in_pvld & ~skid_vld;
   assign fire_c   = pipe_vld & out_prdy;

   assign out_pvld = pipe_vld;
   assign out_pd   = pipe_pd;
   assign in_prdy  = ~skid_vld;
   assign occ      = 2'({1'b0, pipe_vld}) + 2'({1'b0, skid_vld});

   // State register and payload storage.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state   <= EMPTY;
         pipe_pd <= '0;
         skid_pd <= '0;
      end else begin
         state   <= state_nxt;
         pipe_pd <= pipe_pd_nxt;
         skid_pd <= skid_pd_nxt;
      end
   end

   // Next-state and payload steering.
   always_comb begin
      state_nxt   = state;
      pipe_pd_nxt = pipe_pd;
      skid_pd_nxt = skid_pd;
      case (state)
         EMPTY: begin
            if (acc_c) begin
               state_nxt   = HALF;
               pipe_pd_nxt = in_pd;
            end
         end
         HALF: begin
            if (acc_c && fire_c) begin
               pipe_pd_nxt = in_pd;
            end else if (acc_c) begin
               state_nxt   = FULL;
               skid_pd_nxt = in_pd;
            end else if (fire_c) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (fire_c) begin
               state_nxt   = HALF;
               pipe_pd_nxt = skid_pd;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Clear wins over a same-cycle transfer.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         xfer_cnt <= '0;
      end else if (cnt_clr) begin
         xfer_cnt <= '0;
      end else if (fire_c) begin
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fp16_out_skid_pipe.sv
// Directed vector bench for fp16_out_skid_pipe (CNT_W = 4 to reach the counter wrap quickly).
module tb_fp16_out_skid_pipe;

   logic        clk;
   logic        rstn;
   logic        in_pvld;
   logic        in_prdy;
   logic [15:0] in_pd;
   logic        out_pvld;
   logic        out_prdy;
   logic [15:0] out_pd;
   logic [1:0]  occ;
   logic        cnt_clr;
   logic [3:0]  xfer_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        pvld;
      logic [15:0] pd;
      logic        prdy;
      logic        clr;
      logic        e_vld;
      logic [15:0] e_pd;
      logic        e_rdy;
      logic [1:0]  e_occ;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   fp16_out_skid_pipe #(.WIDTH(16), .CNT_W(4)) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .in_pvld        (in_pvld),
      .in_prdy        (in_prdy),
      .in_pd          (in_pd),
      .out_pvld       (out_pvld),
      .out_prdy       (out_prdy),
      .out_pd         (out_pd),
      .occ            (occ),
      .cnt_clr        (cnt_clr),
      .xfer_cnt       (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic pvld, input logic [15:0] pd, input logic prdy, input logic clr,
                      input logic e_vld, input logic [15:0] e_pd, input logic e_rdy,
                      input logic [1:0] e_occ, input logic [3:0] e_cnt);
      vec_t v;
      v.pvld = pvld; v.pd = pd; v.prdy = prdy; v.clr = clr;
      v.e_vld = e_vld; v.e_pd = e_pd; v.e_rdy = e_rdy; v.e_occ = e_occ; v.e_cnt = e_cnt;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic pvld, input logic [15:0] pd, input logic prdy, input logic clr);
      @(negedge clk);
      in_pvld  = pvld;
      in_pd    = pd;
      out_prdy = prdy;
      cnt_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic e_vld, input logic [15:0] e_pd,
                           input logic e_rdy, input logic [1:0] e_occ, input logic [3:0] e_cnt);
      chk({tag, "_vld"}, 32'(out_pvld), 32'(e_vld));
      if (e_vld) chk({tag, "_pd"}, 32'(out_pd), 32'(e_pd));
      chk({tag, "_rdy"}, 32'(in_prdy), 32'(e_rdy));
      chk({tag, "_occ"}, 32'(occ), 32'(e_occ));
      chk({tag, "_cnt"}, 32'(xfer_cnt), 32'(e_cnt));
   endtask

   initial begin
      // Idle, then streaming with out_prdy high.
      add(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 2'd0, 4'd0);
      add(1, 16'h3C00, 1, 0,  1, 16'h3C00, 1, 2'd1, 4'd0);
      add(1, 16'h4000, 1, 0,  1, 16'h4000, 1, 2'd1, 4'd1);
      add(1, 16'h4200, 1, 0,  1, 16'h4200, 1, 2'd1, 4'd2);
      add(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 2'd0, 4'd3);
      // Backpressure: fill both entries, third word refused, head stable.
      add(1, 16'h1111, 0, 0,  1, 16'h1111, 1, 2'd1, 4'd3);
      add(1, 16'h2222, 0, 0,  1, 16'h1111, 0, 2'd2, 4'd3);
      add(1, 16'h3333, 0, 0,  1, 16'h1111, 0, 2'd2, 4'd3);
      add(1, 16'h3333, 0, 0,  1, 16'h1111, 0, 2'd2, 4'd3);
      // Release: skid drains into main, then 0x3333 is taken.
      add(1, 16'h3333, 1, 0,  1, 16'h2222, 1, 2'd1, 4'd4);
      add(1, 16'h3333, 1, 0,  1, 16'h3333, 1, 2'd1, 4'd5);
      add(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 2'd0, 4'd6);
      // Empty: in_pd and out_prdy are don't-cares.
      add(0, 16'hFFFF, 1, 0,  0, 16'h0000, 1, 2'd0, 4'd6);
      add(0, 16'h0000, 0, 1,  0, 16'h0000, 1, 2'd0, 4'd0);
      // 17 fires with CNT_W = 4 wraps to 1.
      for (int k = 0; k <= 16; k++)
         add(1, 16'h0100 + 16'(k), 1, 0,  1, 16'h0100 + 16'(k), 1, 2'd1, 4'(k));
      add(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 2'd0, 4'd1);
      // Clear coincident with a fire: transfer not counted.
      add(1, 16'h5555, 0, 0,  1, 16'h5555, 1, 2'd1, 4'd1);
      add(0, 16'h0000, 1, 1,  0, 16'h0000, 1, 2'd0, 4'd0);

      rstn = 1'b0; in_pvld = 1'b0; in_pd = '0; out_prdy = 1'b0; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_outs("reset", 1'b0, 16'h0000, 1'b1, 2'd0, 4'd0);
      chk("reset_pd", 32'(out_pd), 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].pvld, vecs[i].pd, vecs[i].prdy, vecs[i].clr);
         chk_outs($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_pd, vecs[i].e_rdy,
                  vecs[i].e_occ, vecs[i].e_cnt);
      end

      // Async reset while FULL clears outputs before the next edge.
      drive(1, 16'hAAAA, 0, 0);
      drive(1, 16'hBBBB, 0, 0);
      chk_outs("full", 1'b1, 16'hAAAA, 1'b0, 2'd2, 4'd0);
      @(negedge clk);
      in_pvld = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk_outs("arst", 1'b0, 16'h0000, 1'b1, 2'd0, 4'd0);
      chk("arst_pd", 32'(out_pd), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      drive(1, 16'hCCCC, 1, 0);
      chk_outs("post_rst", 1'b1, 16'hCCCC, 1'b1, 2'd1, 4'd0);
      drive(0, 16'h0000, 1, 0);
      chk_outs("post_drain", 1'b0, 16'h0000, 1'b1, 2'd0, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
